// File: rtl/cte.sv
// Colour transform engine: converts a packed U Y V Y byte stream (4:2:2)
// into 24-bit RGB pixels (op_mode=0), or 24-bit RGB pixels into a
// U Y V Y byte stream (op_mode=1).
//
// Handshake: a word on yuv_in/rgb_in is taken on a rising edge where
// in_en=1 and busy=0; otherwise the source must hold it. out_valid is a
// single-cycle strobe qualifying rgb_out (op_mode=0) or yuv_out (op_mode=1);
// there is no back-pressure on the output side.
//
// Arithmetic is exact: every channel is formed as 1000 x (exact value),
// biased by +500 and floor-divided by 1000 (round half toward +inf), then
// clamped. No fixed-point approximation is involved.
module cte (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_mode,
   input  logic        in_en,
   input  logic [7:0]  yuv_in,
   input  logic [23:0] rgb_in,
   output logic        busy,
   output logic        out_valid,
   output logic [23:0] rgb_out,
   output logic [7:0]  yuv_out
);

   // Emission sequencer for the even pixel in RGB->YUV mode. U leaves on
   // the accept edge; Y and V follow on the next two edges.
   typedef enum logic [1:0] {
      EMIT_IDLE = 2'd0,
      EMIT_Y    = 2'd1,
      EMIT_V    = 2'd2
   } emit_t;

   emit_t       emit_q;
   logic [1:0]  phase_q;     // position in the U0 Y0 V0 Y1 group
   logic        mode_q;      // op_mode seen on the previous edge
   logic [7:0]  u_q;         // YUV->RGB: captured U0
   logic [7:0]  y_q;         // YUV->RGB: captured Y0
   logic [7:0]  v_q;         // YUV->RGB: captured V0
   logic [7:0]  pend_y_q;    // RGB->YUV: Y of the even pixel awaiting emission
   logic [7:0]  pend_v_q;    // RGB->YUV: V of the even pixel awaiting emission

   logic        accept;
   logic        mode_change;
   logic [1:0]  cur_phase;
   logic [7:0]  pix_y;
   logic [7:0]  pix_v;
   logic [23:0] rgb_calc;
   logic [23:0] yuv_calc;    // {Y, U, V}

   // ------------------------------------------------------------------
   // Arithmetic helpers (all values carried as signed 21-bit integers)
   // ------------------------------------------------------------------
   function automatic logic signed [20:0] zext(input logic [7:0] b);
      return {13'd0, b};
   endfunction

   function automatic logic signed [20:0] sext(input logic [7:0] b);
      return {{13{b[7]}}, b};
   endfunction

   // milli = 1000 x exact value; round half up and clamp to 0..255
   function automatic logic [7:0] round_u8(input logic signed [20:0] milli);
      logic signed [20:0] biased;
      logic [20:0]        q;
      biased = milli + 21'sd500;
      if (biased[20]) begin
         return 8'h00;
      end
      q = $unsigned(biased) / 21'd1000;
      if (q > 21'd255) begin
         return 8'hFF;
      end
      return q[7:0];
   endfunction

   // milli = 1000 x exact value; round half up and clamp to -128..127.
   // The +128000 offset keeps the dividend non-negative so that unsigned
   // division equals floor division.
   function automatic logic [7:0] round_s8(input logic signed [20:0] milli);
      logic signed [20:0] biased;
      logic [20:0]        q;
      biased = milli + 21'sd500 + 21'sd128000;
      if (biased[20]) begin
         return 8'h80;
      end
      q = $unsigned(biased) / 21'd1000;
      if (q > 21'd255) begin
         return 8'h7F;
      end
      return q[7:0] ^ 8'h80;
   endfunction

   function automatic logic [23:0] yuv2rgb(input logic [7:0] u,
                                           input logic [7:0] y,
                                           input logic [7:0] v);
      logic signed [20:0] ys, us, vs;
      logic [7:0]         r, g, b;
      ys = zext(y);
      us = sext(u);
      vs = sext(v);
      r  = round_u8(21'sd1000 * ys + 21'sd1402 * vs);
      g  = round_u8(21'sd1000 * ys - 21'sd344 * us - 21'sd714 * vs);
      b  = round_u8(21'sd1000 * ys + 21'sd1772 * us);
      return {r, g, b};
   endfunction

   function automatic logic [23:0] rgb2yuv(input logic [23:0] p);
      logic signed [20:0] rs, gs, bs;
      logic [7:0]         y, u, v;
      rs = zext(p[23:16]);
      gs = zext(p[15:8]);
      bs = zext(p[7:0]);
      y  = round_u8(21'sd299 * rs + 21'sd587 * gs + 21'sd114 * bs);
      u  = round_s8(21'sd500 * bs - 21'sd169 * rs - 21'sd331 * gs);
      v  = round_s8(21'sd500 * rs - 21'sd419 * gs - 21'sd81 * bs);
      return {y, u, v};
   endfunction

   // Accept qualification, effective phase and converter operand selection
   always_comb begin
      accept      = in_en & ~busy;
      mode_change = (op_mode != mode_q);
      cur_phase   = mode_change ? 2'd0 : phase_q;
      pix_y       = (cur_phase == 2'd3) ? yuv_in : y_q;
      pix_v       = (cur_phase == 2'd2) ? yuv_in : v_q;
      rgb_calc    = yuv2rgb(u_q, pix_y, pix_v);
      yuv_calc    = rgb2yuv(rgb_in);
   end

   // Phase tracking, operand capture, emission sequencing and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         emit_q    <= EMIT_IDLE;
         phase_q   <= 2'd0;
         mode_q    <= 1'b0;
         u_q       <= 8'h00;
         y_q       <= 8'h00;
         v_q       <= 8'h00;
         pend_y_q  <= 8'h00;
         pend_v_q  <= 8'h00;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         rgb_out   <= 24'h000000;
         yuv_out   <= 8'h00;
      end else begin
         mode_q    <= op_mode;
         out_valid <= 1'b0;

         // A mode switch abandons any partially collected group
         if (mode_change) begin
            phase_q <= 2'd0;
         end

         // Already scheduled bytes always drain, even across a mode switch;
         // busy stays high meanwhile so no new input can collide with them.
         case (emit_q)
            EMIT_Y: begin
               yuv_out   <= pend_y_q;
               out_valid <= 1'b1;
               emit_q    <= EMIT_V;
            end
            EMIT_V: begin
               yuv_out   <= pend_v_q;
               out_valid <= 1'b1;
               busy      <= 1'b0;
               emit_q    <= EMIT_IDLE;
            end
            default: begin
            end
         endcase

         if (accept) begin
            if (!op_mode) begin
               // YUV->RGB: a pixel leaves with V0 and again with Y1
               case (cur_phase)
                  2'd0: u_q <= yuv_in;
                  2'd1: y_q <= yuv_in;
                  2'd2: begin
                     v_q       <= yuv_in;
                     rgb_out   <= rgb_calc;
                     out_valid <= 1'b1;
                  end
                  default: begin
                     rgb_out   <= rgb_calc;
                     out_valid <= 1'b1;
                  end
               endcase
               phase_q <= cur_phase + 2'd1;
            end else if (cur_phase == 2'd0) begin
               // RGB->YUV even pixel: it supplies U0, Y0 and V0 of the group
               yuv_out   <= yuv_calc[15:8];
               out_valid <= 1'b1;
               pend_y_q  <= yuv_calc[23:16];
               pend_v_q  <= yuv_calc[7:0];
               busy      <= 1'b1;
               emit_q    <= EMIT_Y;
               phase_q   <= 2'd3;
            end else begin
               // RGB->YUV odd pixel: only Y1 is sent
               yuv_out   <= yuv_calc[23:16];
               out_valid <= 1'b1;
               phase_q   <= 2'd0;
            end
         end
      end
   end

endmodule

// File: tb/tb_cte.sv
// Testbench for the colour transform engine. Stimulus drivers push expected
// outputs (value plus arrival cycle) into a queue; a negedge monitor pops
// and compares whenever out_valid is seen, and checks busy every cycle.
module tb_cte;

   logic        clk = 1'b0;
   logic        reset;
   logic        op_mode;
   logic        in_en;
   logic [7:0]  yuv_in;
   logic [23:0] rgb_in;
   logic        busy;
   logic        out_valid;
   logic [23:0] rgb_out;
   logic [7:0]  yuv_out;

   cte dut (
      .clk       (clk),
      .reset     (reset),
      .op_mode   (op_mode),
      .in_en     (in_en),
      .yuv_in    (yuv_in),
      .rgb_in    (rgb_in),
      .busy      (busy),
      .out_valid (out_valid),
      .rgb_out   (rgb_out),
      .yuv_out   (yuv_out)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   // bit 24: 1 = yuv_out byte, 0 = rgb_out pixel
   logic [24:0] exp_q[$];
   int          exp_t_q[$];
   logic [24:0] dir_q[$];     // literal expectations overriding the model
   int          tests = 0;
   int          fails = 0;
   int          n_out = 0;
   int          busy_lo = 0;
   int          busy_hi = -1;

   // reference model state
   int          m_phase = 0;
   bit          m_odd = 1'b0;
   logic [7:0]  m_u = 8'h00;
   logic [7:0]  m_y = 8'h00;
   logic [7:0]  m_v = 8'h00;

   // ---------------- reference model ----------------
   function automatic int fdiv(int a, int b);
      if (a >= 0) return a / b;
      return -((-a + b - 1) / b);
   endfunction

   // milli = 1000 x exact value; nearest integer, halves go up
   function automatic int rnd(int milli);
      int q;
      q = fdiv(milli, 1000);
      if (milli - q * 1000 >= 500) q = q + 1;
      return q;
   endfunction

   function automatic int clamp(int x, int lo, int hi);
      if (x < lo) return lo;
      if (x > hi) return hi;
      return x;
   endfunction

   function automatic int sbyte(logic [7:0] b);
      return (b >= 8'd128) ? int'(b) - 256 : int'(b);
   endfunction

   function automatic logic [23:0] ref_rgb(logic [7:0] u, logic [7:0] y, logic [7:0] v);
      int uu, vv, yy, r, g, b;
      uu = sbyte(u);
      vv = sbyte(v);
      yy = int'(y);
      r  = clamp(rnd(1000 * yy + 1402 * vv), 0, 255);
      g  = clamp(rnd(1000 * yy - 344 * uu - 714 * vv), 0, 255);
      b  = clamp(rnd(1000 * yy + 1772 * uu), 0, 255);
      return {r[7:0], g[7:0], b[7:0]};
   endfunction

   // returns {Y, U, V}
   function automatic logic [23:0] ref_yuv(logic [23:0] p);
      int r, g, b, y, u, v;
      r = int'(p[23:16]);
      g = int'(p[15:8]);
      b = int'(p[7:0]);
      y = clamp(rnd(299 * r + 587 * g + 114 * b), 0, 255);
      u = clamp(rnd(-169 * r - 331 * g + 500 * b), -128, 127);
      v = clamp(rnd(500 * r - 419 * g - 81 * b), -128, 127);
      return {y[7:0], u[7:0], v[7:0]};
   endfunction

   // ---------------- checking helpers ----------------
   task automatic check(string name, logic [31:0] act, logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic expect_out(logic [24:0] model_val, int t);
      logic [24:0] e;
      e = model_val;
      if (dir_q.size() > 0) e = dir_q.pop_front();
      exp_q.push_back(e);
      exp_t_q.push_back(t);
   endtask

   // ---------------- monitor ----------------
   logic [24:0] mon_e;
   int          mon_t;
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         check("busy", busy, (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
         if (out_valid === 1'b1) begin
            n_out++;
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_output: out_valid=1 at cycle %0d rgb_out=%h yuv_out=%h, required no output",
                        cyc, rgb_out, yuv_out);
            end else begin
               mon_e = exp_q.pop_front();
               mon_t = exp_t_q.pop_front();
               check("out_cycle", cyc, mon_t);
               if (mon_e[24]) check("yuv_out", {24'd0, yuv_out}, {24'd0, mon_e[7:0]});
               else           check("rgb_out", {8'd0, rgb_out}, {8'd0, mon_e[23:0]});
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Holds the offered word until an edge with busy=0; k = accept cycle.
   task automatic wait_accept(output int k);
      int guard;
      bit done;
      guard = 0;
      done  = 1'b0;
      k     = -1;
      while (!done) begin
         @(negedge clk);
         if (busy === 1'b0) begin
            k    = cyc + 1;
            done = 1'b1;
         end
         @(posedge clk);
         #1;
         guard++;
         if (!done && guard > 20) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: busy=%b after 20 cycles, required 0", busy);
            done = 1'b1;
         end
      end
   endtask

   task automatic send_yuv(logic [7:0] b);
      int k;
      in_en  = 1'b1;
      yuv_in = b;
      wait_accept(k);
      if (k >= 0) begin
         case (m_phase)
            0: m_u = b;
            1: m_y = b;
            2: begin
               m_v = b;
               expect_out({1'b0, ref_rgb(m_u, m_y, b)}, k);
            end
            default: expect_out({1'b0, ref_rgb(m_u, b, m_v)}, k);
         endcase
         m_phase = (m_phase + 1) % 4;
      end
   endtask

   task automatic send_rgb(logic [23:0] p);
      int k;
      logic [23:0] c;
      in_en  = 1'b1;
      rgb_in = p;
      wait_accept(k);
      if (k >= 0) begin
         c = ref_yuv(p);
         if (!m_odd) begin
            expect_out({1'b1, 16'd0, c[15:8]},  k);
            expect_out({1'b1, 16'd0, c[23:16]}, k + 1);
            expect_out({1'b1, 16'd0, c[7:0]},   k + 2);
            busy_lo = k;
            busy_hi = k + 1;
         end else begin
            expect_out({1'b1, 16'd0, c[23:16]}, k);
         end
         m_odd = !m_odd;
      end
   endtask

   task automatic idle(int n);
      in_en = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_mode(logic m);
      in_en   = 1'b0;
      op_mode = m;
      m_phase = 0;
      m_odd   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic drain(string name);
      int g;
      g     = 0;
      in_en = 1'b0;
      while (exp_q.size() > 0 && g < 100) begin
         @(posedge clk);
         g++;
      end
      repeat (3) @(posedge clk);
      #1;
      check(name, exp_q.size(), 0);
      exp_q.delete();
      exp_t_q.delete();
   endtask

   task automatic do_reset(string tag);
      reset = 1'b0;
      in_en = 1'b0;
      #1;
      exp_q.delete();
      exp_t_q.delete();
      dir_q.delete();
      busy_lo = 0;
      busy_hi = -1;
      m_phase = 0;
      m_odd   = 1'b0;
      check({tag, "_busy"},      busy,      0);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_rgb_out"},   rgb_out,   0);
      check({tag, "_yuv_out"},   yuv_out,   0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   logic [7:0]  dir_bytes[12] = '{8'h00, 8'h80, 8'h00, 8'h80,
                                  8'h00, 8'h10, 8'h7F, 8'hEB,
                                  8'h80, 8'h80, 8'h80, 8'h80};
   logic [23:0] dir_pix[6]   = '{24'h808080, 24'h808080,
                                  24'hC20010, 24'hFF90EB,
                                  24'h00FF00, 24'h00FF00};
   logic [7:0]  corner_bytes[8] = '{8'h7F, 8'hFF, 8'h80, 8'h00,
                                    8'h80, 8'h00, 8'h7F, 8'hFF};
   logic [23:0] corner_pix[6] = '{24'hFF0000, 24'h00FF00, 24'h0000FF,
                                  24'h808080, 24'h123456, 24'hFFFF00};

   initial begin
      int start;
      op_mode = 1'b0;
      in_en   = 1'b0;
      yuv_in  = 8'h00;
      rgb_in  = 24'h000000;
      reset   = 1'b1;
      #2;
      do_reset("reset");

      // YUV->RGB directed vectors, back to back
      foreach (dir_pix[i]) dir_q.push_back({1'b0, dir_pix[i]});
      foreach (dir_bytes[i]) send_yuv(dir_bytes[i]);
      drain("m0_directed_drain");

      // YUV->RGB extremes, then random bytes with random gaps
      foreach (corner_bytes[i]) send_yuv(corner_bytes[i]);
      for (int i = 0; i < 40; i++) begin
         send_yuv(8'($urandom_range(0, 255)));
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      drain("m0_random_drain");

      // 1000-byte continuous stream plus one trailing byte
      start = n_out;
      for (int i = 0; i < 1001; i++) send_yuv(8'($urandom_range(0, 255)));
      drain("m0_stream_drain");
      idle(10);
      check("m0_stream_count", n_out - start, 500);

      // RGB->YUV directed: white then black; second pixel waits out busy
      set_mode(1'b1);
      dir_q.push_back({1'b1, 16'd0, 8'h00});
      dir_q.push_back({1'b1, 16'd0, 8'hFF});
      dir_q.push_back({1'b1, 16'd0, 8'h00});
      dir_q.push_back({1'b1, 16'd0, 8'h00});
      send_rgb(24'hFFFFFF);
      send_rgb(24'h000000);
      drain("m1_directed_drain");

      // RGB->YUV extremes and random pixels with random gaps
      foreach (corner_pix[i]) send_rgb(corner_pix[i]);
      for (int i = 0; i < 30; i++) begin
         send_rgb(24'($urandom));
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end
      drain("m1_random_drain");

      // Mode switch right after an even pixel: its U/Y/V still arrive
      set_mode(1'b1);
      send_rgb(24'($urandom));
      set_mode(1'b0);
      for (int i = 0; i < 4; i++) send_yuv(8'($urandom_range(0, 255)));
      drain("mode_switch_drain");

      // Partial YUV group dropped by a mode round trip
      send_yuv(8'($urandom_range(0, 255)));
      send_yuv(8'($urandom_range(0, 255)));
      set_mode(1'b1);
      set_mode(1'b0);
      for (int i = 0; i < 4; i++) send_yuv(8'($urandom_range(0, 255)));
      drain("partial_drop_drain");

      // Reset during an emission, then restart from U
      set_mode(1'b1);
      send_rgb(24'($urandom));
      @(negedge clk);
      #2;
      do_reset("mid_reset");
      dir_q.push_back({1'b1, 16'd0, 8'h00});
      dir_q.push_back({1'b1, 16'd0, 8'hFF});
      dir_q.push_back({1'b1, 16'd0, 8'h00});
      dir_q.push_back({1'b1, 16'd0, 8'h00});
      send_rgb(24'hFFFFFF);
      send_rgb(24'h000000);
      drain("restart_drain");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Hard time limit so the run always ends
   initial begin
      #500000;
      fails++;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/cte.md
Name:
cte

Overview:
- Color Transform Engine: streaming colour-space converter between packed YUV 4:2:2 bytes and 24-bit RGB pixels.
- op_mode=0 converts a YUV byte stream to RGB pixels. op_mode=1 converts RGB pixels to a YUV byte stream.
- Sits between a pixel source and sink, with an in_en/busy input handshake and an out_valid output strobe.

Parameters:
- None. Widths are fixed: 8-bit components, 24-bit RGB.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- op_mode  in  1  0 = YUV→RGB, 1 = RGB→YUV.
- in_en  in  1  input data valid.
- yuv_in  in  8  YUV byte input (mode 0).
- rgb_in  in  24  RGB pixel input {R[23:16],G[15:8],B[7:0]} (mode 1).
- busy  out  1  high = input not accepted this cycle.
- out_valid  out  1  one-cycle strobe qualifying rgb_out or yuv_out.
- rgb_out  out  24  converted RGB pixel (mode 0).
- yuv_out  out  8  converted YUV byte (mode 1).

Behaviour:
- Reset (reset=0, asynchronous): busy=0, out_valid=0, rgb_out=0, yuv_out=0, phase counter=0, component registers cleared.
- Accept rule: an input is taken on a rising edge where in_en=1 and busy=0. Input is ignored when busy=1 or in_en=0; the phase does not advance.
- Byte/pixel order, both modes, repeating groups of 4 bytes: U0 Y0 V0 Y1.
  - U and V belong to the pixel pair (pixel0, pixel1).
  - Phase counter 0..3 wraps 3→0.
- Number formats:
  - Y is unsigned 0..255.
  - U and V are signed two's-complement −128..127, with no 128 offset.
- Mode 0 (YUV→RGB):
  - busy stays 0; one byte can be accepted every cycle.
  - Pixel0 is emitted after V0 is accepted, using U0, Y0, V0.
  - Pixel1 is emitted after Y1 is accepted, using U0, Y1, V0.
  - Latency: rgb_out is valid and out_valid=1 on the rising edge following the completing byte's accept edge, for exactly one cycle.
  - Accepting U or Y0 produces no output.
  - One output per Y byte: 2N bytes in give N pixels out.
  - Equations:
    - R = Y + 1.402·V
    - G = Y − 0.344·U − 0.714·V
    - B = Y + 1.772·U
- Mode 1 (RGB→YUV):
  - Even pixel accepted (phase A): emit U, Y, V of that pixel on 3 consecutive cycles. busy=1 for the 2 cycles following the accept.
  - Odd pixel accepted: emit only its Y, one cycle later. busy stays 0.
  - out_valid=1 exactly on each emitted yuv_out byte.
  - Equations:
    - Y = 0.299R + 0.587G + 0.114B
    - U = −0.169R − 0.331G + 0.5B
    - V = 0.5R − 0.419G − 0.081B
- Arithmetic, all outputs:
  - Evaluate exactly with the stated decimal coefficients.
  - Round to nearest integer, ties toward +∞.
  - Saturate: R, G, B, Y to 0..255; U, V to −128..127.
  - Fixed-point implementation allowed only if bit-exact to this definition over all inputs; verify exhaustively.
- op_mode change:
  - A change seen on a rising edge resets the phase to 0 and drops any partial group.
  - A change does not cancel an output already scheduled.
- Incomplete trailing group: no output; state is held until more data or reset.
- Reset mid-operation clears everything immediately, including pending outputs and busy.

Test Plan:
- Reset asserted → busy=0, out_valid=0, rgb_out=000000, yuv_out=00.
- Mode 0, bytes 00 80 00 80 → two pixels 808080, 808080, each out_valid one cycle after V0 / Y1 accept.
- Mode 0, bytes 00 10 7F EB → pixel0 C20010 (G clipped low), pixel1 FF90EB (R clipped high).
- Mode 0, bytes 80 80 80 80 (U=V=−128) → pixel0 00FF00, pixel1 00FF00.
- Mode 0, 1000-byte back-to-back stream with in_en continuously high, plus one extra trailing byte → exactly 500 outputs in order; busy never 1; trailing byte yields no output.
- Mode 1:
  - rgb_in FFFFFF then 000000 → yuv_out 00, FF, 00, 00.
  - busy high 2 cycles after the first pixel; an in_en offered during busy is ignored and retained by the source.
  - Reset mid-group, then restart → phase restarts at U.
